branch_target_predictor: RTL and testbench

- Parametrised direct-mapped branch target buffer with per-entry saturating direction counters for the 5-stage pipelined MIPS core.
- Fetch presents the PC each cycle and gets a taken/target prediction. Decode/execute returns the resolved outcome of beq, bne and j, and the block trains on it.
- Also keeps saturating update and mispredict statistics for the bench.
- Adds dynamic prediction on top of the core's existing resolve-in-decode branch path.

---
 rtl/branch_target_predictor.sv | 121 ++++++++++++
 tb/tb_branch_target_predictor.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Fetch looks up continuously; resolved branches from decode/execute train the array.
module branch_target_predictor #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] f_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              u_valid,
    input  logic [ADDR_W-1:0] u_pc,
    input  logic              u_taken,
    input  logic [ADDR_W-1:0] u_target,
    input  logic              u_is_jump,
    input  logic              u_pred_taken,
    input  logic [ADDR_W-1:0] u_pred_target,
    input  logic              flush,
    output logic              mispredict,
    output logic [STAT_W-1:0] update_cnt,
    output logic [STAT_W-1:0] mispredict_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - 1'b1;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] c);
        return (c == '0) ? c : c - 1'b1;
    endfunction

    function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] s, input logic en);
        return (en && !(&s)) ? s + 1'b1 : s;
    endfunction

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic              jump_q   [ENTRIES];
    logic [CNT_W-1:0]  cnt_q    [ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic             u_mis;
    logic             u_accept;
    logic             unused_pc_bits;

    assign f_idx = f_pc[IDX_W+1:2];
    assign f_tag = f_pc[ADDR_W-1:IDX_W+2];
    assign u_idx = u_pc[IDX_W+1:2];
    assign u_tag = u_pc[ADDR_W-1:IDX_W+2];
    assign unused_pc_bits = ^{f_pc[1:0], u_pc[1:0]};

    // Lookup stage: purely combinational from registered array contents, no update bypass
    always_comb begin
        pred_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        pred_taken  = pred_hit && (jump_q[f_idx] || cnt_q[f_idx][CNT_W-1]);
        pred_target = pred_hit ? target_q[f_idx] : '0;
    end

    always_comb begin
        u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        u_mis    = (u_taken != u_pred_taken) || (u_taken && (u_target != u_pred_target));
        u_accept = u_valid && !flush;
    end

    // Training stage: array and statistics written on the clock edge
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                jump_q[i]   <= 1'b0;
                cnt_q[i]    <= CNT_WNT;
            end
            update_cnt     <= '0;
            mispredict_cnt <= '0;
            mispredict     <= 1'b0;
        end else begin
            mispredict     <= u_accept && u_mis;
            update_cnt     <= stat_inc(update_cnt, u_accept);
            mispredict_cnt <= stat_inc(mispredict_cnt, u_accept && u_mis);
            if (flush) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    valid_q[i] <= 1'b0;
                end
            end else if (u_valid) begin
                if (u_hit) begin
                    if (u_taken) begin
                        cnt_q[u_idx]    <= cnt_inc(cnt_q[u_idx]);
                        target_q[u_idx] <= u_target;
                        jump_q[u_idx]   <= u_is_jump;
                    end else begin
                        cnt_q[u_idx] <= cnt_dec(cnt_q[u_idx]);
                    end
                end else if (u_taken) begin
                    // Taken miss steals the slot whatever it held before
                    valid_q[u_idx]  <= 1'b1;
                    tag_q[u_idx]    <= u_tag;
                    target_q[u_idx] <= u_target;
                    jump_q[u_idx]   <= u_is_jump;
                    cnt_q[u_idx]    <= CNT_WT;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: an entry-level model checked every cycle,
// plus literal expectations along the test plan.
module tb_branch_target_predictor;

    logic        clock;
    logic        reset;
    logic [31:0] f_pc;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        u_valid, u_taken, u_is_jump, u_pred_taken, flush;
    logic [31:0] u_pc, u_target, u_pred_target;
    logic        mispredict;
    logic [15:0] update_cnt, mispredict_cnt;
    logic        pred_hit4, pred_taken4, mispredict4;
    logic [31:0] pred_target4;
    logic [3:0]  update_cnt4, mispredict_cnt4;

    branch_target_predictor #(.ADDR_W(32), .ENTRIES(16), .CNT_W(2), .STAT_W(16)) u_dut (
        .clock(clock), .reset(reset), .f_pc(f_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .u_valid(u_valid), .u_pc(u_pc), .u_taken(u_taken), .u_target(u_target),
        .u_is_jump(u_is_jump), .u_pred_taken(u_pred_taken), .u_pred_target(u_pred_target),
        .flush(flush), .mispredict(mispredict),
        .update_cnt(update_cnt), .mispredict_cnt(mispredict_cnt)
    );

    branch_target_predictor #(.ADDR_W(32), .ENTRIES(16), .CNT_W(2), .STAT_W(4)) u_dut4 (
        .clock(clock), .reset(reset), .f_pc(f_pc),
        .pred_hit(pred_hit4), .pred_taken(pred_taken4), .pred_target(pred_target4),
        .u_valid(u_valid), .u_pc(u_pc), .u_taken(u_taken), .u_target(u_target),
        .u_is_jump(u_is_jump), .u_pred_taken(u_pred_taken), .u_pred_target(u_pred_target),
        .flush(flush), .mispredict(mispredict4),
        .update_cnt(update_cnt4), .mispredict_cnt(mispredict_cnt4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one record per slot, tag = pc >> 6, counter as a plain integer 0..3
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    bit          m_jump  [16];
    int          m_cnt   [16];
    int          m_upd, m_mis;
    bit          m_misp;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 0; m_cnt[i] = 1; m_tgt[i] = 0; m_tag[i] = 0; m_jump[i] = 0;
            end
            m_upd = 0; m_mis = 0; m_misp = 0;
        end else if (flush) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 0;
            m_misp = 0;
        end else if (u_valid) begin
            int  s;
            bit  mp;
            s  = slot(u_pc);
            mp = (u_taken != u_pred_taken) || (u_taken && u_target != u_pred_target);
            m_upd++;
            if (mp) m_mis++;
            m_misp = mp;
            if (m_valid[s] && m_tag[s] == (u_pc >> 6)) begin
                if (u_taken) begin
                    m_cnt[s]  = (m_cnt[s] < 3) ? m_cnt[s] + 1 : 3;
                    m_tgt[s]  = u_target;
                    m_jump[s] = u_is_jump;
                end else begin
                    m_cnt[s] = (m_cnt[s] > 0) ? m_cnt[s] - 1 : 0;
                end
            end else if (u_taken) begin
                m_valid[s] = 1; m_tag[s] = u_pc >> 6; m_tgt[s] = u_target;
                m_jump[s] = u_is_jump; m_cnt[s] = 2;
            end
        end else begin
            m_misp = 0;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            int   s;
            bit   e_hit, e_tk;
            logic [31:0] e_tgt;
            s     = slot(f_pc);
            e_hit = m_valid[s] && (m_tag[s] == (f_pc >> 6));
            e_tk  = e_hit && (m_jump[s] || m_cnt[s] >= 2);
            e_tgt = e_hit ? m_tgt[s] : 32'h0;
            chk("cyc_pred_hit", {31'b0, pred_hit}, {31'b0, e_hit});
            chk("cyc_pred_taken", {31'b0, pred_taken}, {31'b0, e_tk});
            chk("cyc_pred_target", pred_target, e_tgt);
            chk("cyc_mispredict", {31'b0, mispredict}, {31'b0, m_misp});
            chk("cyc_update_cnt", {16'b0, update_cnt}, sat(m_upd, 65535));
            chk("cyc_mispredict_cnt", {16'b0, mispredict_cnt}, sat(m_mis, 65535));
            chk("cyc4_pred_target", pred_target4, e_tgt);
            chk("cyc4_update_cnt", {28'b0, update_cnt4}, sat(m_upd, 15));
            chk("cyc4_mispredict_cnt", {28'b0, mispredict_cnt4}, sat(m_mis, 15));
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                       input bit jmp, input bit ptk, input logic [31:0] ptgt);
        u_pc = pc; u_taken = tk; u_target = tgt; u_is_jump = jmp;
        u_pred_taken = ptk; u_pred_target = ptgt; u_valid = 1;
        cyc();
        u_valid = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; flush = 0; f_pc = 32'h40; u_valid = 0; u_pc = 0; u_taken = 0;
        u_target = 0; u_is_jump = 0; u_pred_taken = 0; u_pred_target = 0;
        cyc();
        reset = 0;
        chk_en = 1;
        // 1: reset state
        chk("rst_hit", {31'b0, pred_hit}, 0);
        chk("rst_taken", {31'b0, pred_taken}, 0);
        chk("rst_target", pred_target, 0);
        chk("rst_upd_cnt", {16'b0, update_cnt}, 0);
        chk("rst_mis_cnt", {16'b0, mispredict_cnt}, 0);
        chk("rst_mispredict", {31'b0, mispredict}, 0);

        // 2: first taken allocates
        upd(32'h40, 1, 32'h200, 0, 0, 0);
        chk("alloc_hit", {31'b0, pred_hit}, 1);
        chk("alloc_taken", {31'b0, pred_taken}, 1);
        chk("alloc_target", pred_target, 32'h200);
        chk("alloc_mispredict", {31'b0, mispredict}, 1);
        chk("alloc_upd_cnt", {16'b0, update_cnt}, 1);
        chk("alloc_mis_cnt", {16'b0, mispredict_cnt}, 1);
        cyc();
        chk("mispredict_pulse_end", {31'b0, mispredict}, 0);

        // 3: hysteresis
        upd(32'h40, 0, 0, 0, 1, 32'h200);
        chk("hyst_01_taken", {31'b0, pred_taken}, 0);
        chk("hyst_01_hit", {31'b0, pred_hit}, 1);
        upd(32'h40, 0, 0, 0, 0, 0);
        upd(32'h40, 0, 0, 0, 0, 0);
        upd(32'h40, 1, 32'h200, 0, 0, 0);
        chk("hyst_up01_taken", {31'b0, pred_taken}, 0);
        upd(32'h40, 1, 32'h200, 0, 0, 0);
        chk("hyst_up10_taken", {31'b0, pred_taken}, 1);

        // 4: aliasing and non-allocating miss
        upd(32'h80, 1, 32'h300, 0, 0, 0);
        chk("alias_old_miss", {31'b0, pred_hit}, 0);
        f_pc = 32'h80; #1;
        chk("alias_new_hit", {31'b0, pred_hit}, 1);
        chk("alias_new_target", pred_target, 32'h300);
        upd(32'h1040, 0, 0, 0, 0, 0);
        chk("nt_miss_keeps_target", pred_target, 32'h300);
        f_pc = 32'h1040; #1;
        chk("nt_miss_no_alloc", {31'b0, pred_hit}, 0);

        // 5: jump stays taken with counter at 00
        f_pc = 32'h20;
        upd(32'h20, 1, 32'h100, 1, 0, 0);
        upd(32'h20, 0, 0, 1, 1, 32'h100);
        upd(32'h20, 0, 0, 1, 1, 32'h100);
        chk("jump_taken", {31'b0, pred_taken}, 1);
        chk("jump_target", pred_target, 32'h100);

        // 6a: same-cycle lookup and update, no bypass
        f_pc = 32'h80;
        u_pc = 32'h80; u_taken = 1; u_target = 32'h400; u_is_jump = 0;
        u_pred_taken = 1; u_pred_target = 32'h300; u_valid = 1;
        #2;
        chk("same_cycle_old", pred_target, 32'h300);
        cyc();
        u_valid = 0;
        chk("same_cycle_new", pred_target, 32'h400);

        // 6b: flush drops a simultaneous update
        flush = 1;
        upd(32'h20, 1, 32'h600, 0, 0, 0);
        flush = 0;
        chk("flush_miss_80", {31'b0, pred_hit}, 0);
        chk("flush_upd_cnt", {16'b0, update_cnt}, 12);
        chk("flush_mispredict", {31'b0, mispredict}, 0);
        f_pc = 32'h20; #1;
        chk("flush_miss_20", {31'b0, pred_hit}, 0);

        // 6c: reset with update clears everything
        upd(32'h20, 1, 32'h100, 0, 0, 0);
        reset = 1;
        upd(32'h80, 1, 32'h700, 0, 0, 0);
        reset = 0;
        chk("rst2_hit20", {31'b0, pred_hit}, 0);
        chk("rst2_upd_cnt", {16'b0, update_cnt}, 0);
        chk("rst2_mis_cnt", {16'b0, mispredict_cnt}, 0);
        f_pc = 32'h80; #1;
        chk("rst2_hit80", {31'b0, pred_hit}, 0);

        // 6d: statistics saturation on the narrow instance
        for (int i = 0; i < 20; i++) upd(32'h100 + 32'(i) * 4, 1, 32'h500, 0, 0, 0);
        chk("sat4_mis_cnt", {28'b0, mispredict_cnt4}, 32'hF);
        chk("sat4_upd_cnt", {28'b0, update_cnt4}, 32'hF);
        chk("sat16_mis_cnt", {16'b0, mispredict_cnt}, 20);
        cyc();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
